// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: serialises command/payload frames to an SPI slave and collects READ_DATA bytes from MISO
module spi_master_ctrl #(
  parameter int DATA_W = 8,
  parameter int TURNAROUND = 1,
  parameter int GAP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        cmd,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              seq_err,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);
  localparam int FW = DATA_W + 3;
  localparam int M1 = FW > TURNAROUND ? FW : TURNAROUND;
  localparam int M2 = M1 > GAP ? M1 : GAP;
  localparam int CW = $clog2(M2 + 1);
  typedef enum logic [2:0] {IDLE, SEL, SHIFT, TURN, RECV, GAP_S} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [FW-1:0] sr;
  logic [DATA_W-1:0] rx;
  logic [1:0] cmd_q;
  logic addr_pending, last, rd;
  int lim;
  assign rd = cmd_q == 2'b11;
  assign ready = state == IDLE;
  assign SS_n = state == IDLE || state == GAP_S;
  assign MOSI = state == SHIFT && sr[FW-1];
  assign done = state == GAP_S && cnt == '0;
  always_comb begin
    lim = state == SHIFT ? FW : state == TURN ? TURNAROUND : state == RECV ? DATA_W : GAP;
    last = int'(cnt) == lim - 1;
  end
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = start ? SEL : IDLE;
      SEL:     nxt = SHIFT;
      SHIFT:   nxt = !last ? SHIFT : !rd ? GAP_S : TURNAROUND > 0 ? TURN : RECV;
      TURN:    nxt = last ? RECV : TURN;
      RECV:    nxt = last ? GAP_S : RECV;
      GAP_S:   nxt = last ? IDLE : GAP_S;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      rx <= '0;
      rdata <= '0;
      cmd_q <= '0;
      seq_err <= 1'b0;
      addr_pending <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= (nxt != state || state == IDLE) ? '0 : cnt + 1'b1;
      if (state == IDLE && start) begin
        cmd_q <= cmd;
        sr <= {cmd[1], cmd, wdata};
        if (cmd == 2'b11 && !addr_pending) seq_err <= 1'b1;
      end
      if (state == SHIFT) sr <= {sr[FW-2:0], 1'b0};
      if (state == RECV) begin
        rx <= {rx[DATA_W-2:0], MISO};
        if (last) rdata <= {rx[DATA_W-2:0], MISO};
      end
      if (done) addr_pending <= cmd_q == 2'b10 ? 1'b1 : cmd_q == 2'b11 ? 1'b0 : addr_pending;
    end
  end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: frame-level reference model plus directed and randomized checks of spi_master_ctrl
module tb_spi_master_ctrl;
  logic clk = 0, rst = 1, start = 0, MISO = 0;
  logic [1:0] cmd = 0;
  logic [7:0] wdata = 0, miso_byte = 0, rdata;
  logic ready, done, seq_err, SS_n, MOSI;
  int checks = 0, errors = 0, cyc = 0;
  int lowcnt = 0, last_low = 0, highcnt = 0, last_high = 0, done_cyc = 0, ndone = 0;
  logic [10:0] mosi_word = 0;
  typedef struct {logic ss, mosi, done, rx, miso; logic [7:0] rv; logic [1:0] c;} ent_t;
  ent_t q[$];
  logic [7:0] e_rdata = 0;
  logic e_seq = 0, pend = 0;
  bit live = 0;
  always #5 clk = ~clk;
  spi_master_ctrl dut (.clk(clk), .rst(rst), .start(start), .cmd(cmd), .wdata(wdata), .ready(ready),
    .done(done), .rdata(rdata), .seq_err(seq_err), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic ent_t ent(logic ss, logic mosi, logic dn, logic rx, logic mi, logic [7:0] rv, logic [1:0] c);
    ent_t e;
    e.ss = ss; e.mosi = mosi; e.done = dn; e.rx = rx; e.miso = mi; e.rv = rv; e.c = c;
    return e;
  endfunction
  function automatic void push_frame(logic [1:0] c, logic [7:0] w, logic [7:0] mb);
    logic [10:0] b;
    b = {c[1], c, w};
    q.push_back(ent(0, 0, 0, 0, 0, 0, c));
    for (int i = 10; i >= 0; i--) q.push_back(ent(0, b[i], 0, 0, 0, 0, c));
    if (c == 2'b11) begin
      q.push_back(ent(0, 0, 0, 0, 0, 0, c));
      for (int i = 7; i >= 0; i--) q.push_back(ent(0, 0, 0, 1, mb[i], 0, c));
    end
    q.push_back(ent(1, 0, 1, 0, 0, mb, c));
  endfunction
  always @(posedge clk) begin
    bit idle;
    cyc++;
    live = 1;
    if (rst) begin
      q.delete();
      e_rdata = 0;
      e_seq = 0;
      pend = 0;
    end else begin
      idle = q.size() == 0;
      if (!idle) void'(q.pop_front());
      if (idle && start) begin
        if (cmd == 2'b11 && !pend) e_seq = 1;
        push_frame(cmd, wdata, miso_byte);
      end
      if (q.size() != 0 && q[0].done) begin
        if (q[0].c == 2'b11) begin
          e_rdata = q[0].rv;
          pend = 0;
        end else if (q[0].c == 2'b10) pend = 1;
      end
    end
  end
  always @(negedge clk) if (live) begin
    bit busy;
    busy = q.size() != 0;
    chk("ss_n", SS_n, busy ? q[0].ss : 1'b1);
    chk("mosi", MOSI, busy ? q[0].mosi : 1'b0);
    chk("ready", ready, !busy);
    chk("done", done, busy ? q[0].done : 1'b0);
    chk("rdata", rdata, e_rdata);
    chk("seq_err", seq_err, e_seq);
    if (!SS_n) begin
      if (lowcnt == 0) last_high = highcnt;
      lowcnt++;
      if (lowcnt >= 2 && lowcnt <= 12) mosi_word = {mosi_word[9:0], MOSI};
      highcnt = 0;
    end else begin
      if (lowcnt != 0) last_low = lowcnt;
      lowcnt = 0;
      highcnt++;
    end
    if (done) begin
      done_cyc = cyc;
      ndone++;
    end
    MISO = (busy && q[0].rx) ? q[0].miso : 1'($urandom);
  end
  task automatic sync();
    @(negedge clk);
    #1;
  endtask
  task automatic wait_ready();
    int t = 0;
    while (!ready && t < 40) begin
      sync();
      t++;
    end
    if (!ready) chk("ready_timeout", 0, 1);
  endtask
  task automatic wait_done(input int n0);
    int t = 0;
    while (ndone == n0 && t < 60) begin
      sync();
      t++;
    end
    if (ndone == n0) chk("done_timeout", 0, 1);
  endtask
  task automatic run(input logic [1:0] c, input logic [7:0] w, input logic [7:0] mb, output int lat);
    int k0, n0;
    wait_ready();
    miso_byte = mb; cmd = c; wdata = w; start = 1;
    k0 = cyc; n0 = ndone;
    sync();
    start = 0;
    wait_done(n0);
    lat = done_cyc - k0;
  endtask
  initial begin
    int lat, n0, k0;
    logic [10:0] w1;
    sync();
    for (int i = 0; i < 10; i++) begin
      start = 1'($urandom); cmd = 2'($urandom); wdata = 8'($urandom);
      sync();
      chk("rst_ss_n", SS_n, 1); chk("rst_ready", ready, 1); chk("rst_rdata", rdata, 0);
    end
    rst = 0; start = 0;
    sync();
    run(2'b00, 8'h3C, 8'h00, lat);
    chk("wa_latency", lat, 13); chk("wa_ss_low", last_low, 12); chk("wa_mosi", mosi_word, 11'h03C);
    wait_ready();
    cmd = 2'b01; wdata = 8'h64; start = 1; n0 = ndone;
    sync();
    cmd = 2'b10; wdata = 8'h3C;
    wait_done(n0);
    w1 = mosi_word; n0 = ndone;
    wait_ready();
    sync();
    start = 0;
    wait_done(n0);
    chk("b2b_word1", w1, 11'h164); chk("b2b_ctrl1", w1[10], 0);
    chk("b2b_word2", mosi_word, 11'h63C); chk("b2b_ctrl2", mosi_word[10], 1);
    chk("b2b_gap", last_high, 2);
    run(2'b11, 8'h00, 8'h64, lat);
    chk("rd_latency", lat, 22); chk("rd_ss_low", last_low, 21);
    chk("rd_rdata", rdata, 8'h64); chk("rd_seq_err", seq_err, 0);
    rst = 1;
    sync(); sync();
    rst = 0;
    run(2'b11, 8'hA5, 8'h35, lat);
    chk("seq_err_set", seq_err, 1); chk("seq_rdata", rdata, 8'h35);
    run(2'b00, 8'h11, 8'h00, lat);
    chk("seq_err_sticky", seq_err, 1);
    wait_ready();
    cmd = 2'b01; wdata = 8'h35; start = 1; k0 = cyc; n0 = ndone;
    sync();
    start = 0;
    repeat (6) sync();
    chk("abort_in_shift", cyc - k0, 7);
    rst = 1;
    sync();
    chk("abort_ss_n", SS_n, 1); chk("abort_ready", ready, 1); chk("abort_done", done, 0);
    rst = 0;
    repeat (14) sync();
    chk("abort_no_done", ndone, n0);
    run(2'b00, 8'h2A, 8'h00, lat);
    chk("post_abort_latency", lat, 13); chk("post_abort_mosi", mosi_word, 11'h02A);
    for (int i = 0; i < 3000; i++) begin
      start = $urandom_range(0, 3) == 0;
      cmd = 2'($urandom); wdata = 8'($urandom); miso_byte = 8'($urandom);
      rst = $urandom_range(0, 299) == 0;
      sync();
    end
    rst = 0; start = 0;
    repeat (30) sync();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
